// File: rtl/core_step_sequencer_if.sv
// Signal bundle between the step sequencer and the decoders / PC / register bank / data bus.
interface core_step_sequencer_if;
  logic        rb_ready;
  logic        pc_end;
  logic        is_load;
  logic        is_store;
  logic        reg_w_dec;
  logic        pause_req;
  logic        bus_ready;
  logic        bus_busy;
  logic        pc_enable;
  logic        reg_we;
  logic        bus_rd;
  logic        bus_wr;
  logic        pause_active;
  logic        halted;
  logic        fault;
  logic [2:0]  state;
  logic [31:0] retired;

  modport master (
    input  rb_ready, pc_end, is_load, is_store, reg_w_dec, pause_req, bus_ready, bus_busy,
    output pc_enable, reg_we, bus_rd, bus_wr, pause_active, halted, fault, state, retired
  );

  modport slave (
    output rb_ready, pc_end, is_load, is_store, reg_w_dec, pause_req, bus_ready, bus_busy,
    input  pc_enable, reg_we, bus_rd, bus_wr, pause_active, halted, fault, state, retired
  );
endinterface

// File: rtl/core_step_sequencer.sv
// One-instruction-at-a-time control FSM: fetch, execute, optional bus access or pause, write-back.
// All outputs are decoded from registered state and latched flags only.
module core_step_sequencer #(
  parameter int PAUSE_CYCLES = 16,
  parameter int BUS_TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  core_step_sequencer_if.master sif
);

  typedef enum logic [2:0] {
    RST_WAIT = 3'd0,
    FETCH    = 3'd1,
    EXEC     = 3'd2,
    MEM      = 3'd3,
    WB       = 3'd4,
    PAUSE    = 3'd5,
    HALT     = 3'd6,
    FAULT    = 3'd7
  } state_e;

  localparam logic [7:0] PCNT_INIT = 8'(PAUSE_CYCLES - 1);
  localparam logic [7:0] WCNT_LAST = 8'(BUS_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic        ld_q, ld_d;
  logic        st_q, st_d;
  logic        wb_en_q, wb_en_d;
  logic [31:0] retired_q, retired_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RST_WAIT;
      wcnt_q    <= '0;
      pcnt_q    <= '0;
      ld_q      <= 1'b0;
      st_q      <= 1'b0;
      wb_en_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      pcnt_q    <= pcnt_d;
      ld_q      <= ld_d;
      st_q      <= st_d;
      wb_en_q   <= wb_en_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    pcnt_d    = pcnt_q;
    ld_d      = ld_q;
    st_d      = st_q;
    wb_en_d   = wb_en_q;
    retired_d = retired_q;

    case (state_q)
      RST_WAIT: if (sif.rb_ready) state_d = FETCH;
      FETCH:    state_d = EXEC;
      EXEC: begin
        // load wins when both kinds are flagged
        ld_d    = sif.is_load;
        st_d    = sif.is_store & ~sif.is_load;
        wb_en_d = sif.reg_w_dec & ~sif.is_store & ~sif.pause_req;
        if (sif.pc_end) begin
          state_d = HALT;
        end else if (sif.pause_req) begin
          state_d = PAUSE;
          pcnt_d  = PCNT_INIT;
        end else if (sif.is_load | sif.is_store) begin
          state_d = MEM;
          wcnt_d  = '0;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        wcnt_d = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;
        // the first MEM cycle never completes, so the request is held at least two cycles
        if ((wcnt_q != 8'd0) && sif.bus_ready && !sif.bus_busy)
          state_d = WB;
        else if (wcnt_q >= WCNT_LAST)
          state_d = FAULT;
      end
      WB: begin
        retired_d = retired_q + 32'd1;
        state_d   = FETCH;
      end
      PAUSE: begin
        if (pcnt_q == 8'd0) state_d = WB;
        else                pcnt_d  = pcnt_q - 8'd1;
      end
      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = RST_WAIT;
    endcase

    // losing the register bank abandons whatever is in flight; HALT/FAULT stay put
    if (!sif.rb_ready && state_q != HALT && state_q != FAULT)
      state_d = RST_WAIT;
  end

  assign sif.pc_enable    = (state_q == WB);
  assign sif.reg_we       = (state_q == WB) & wb_en_q;
  assign sif.bus_rd       = (state_q == MEM) & ld_q;
  assign sif.bus_wr       = (state_q == MEM) & st_q;
  assign sif.pause_active = (state_q == PAUSE);
  assign sif.halted       = (state_q == HALT);
  assign sif.fault        = (state_q == FAULT);
  assign sif.state        = state_q;
  assign sif.retired      = retired_q;

endmodule

// File: doc/core_step_sequencer.md
# core_step_sequencer

Multi-cycle control FSM that sequences the RISCuin datapath one instruction at a time: fetch, execute, data-bus access and write-back. It replaces free-running PC enabling with explicit strobes. It gates the program-counter enable, register-bank write, data-bus read/write requests and Zihintpause stalls from decoder flags and bus status. It sits between the instruction decoders and the ProgramCountControlUnit, RegisterBank and DataBusControl.

## Interface
- PAUSE_CYCLES, 16: cycles spent in PAUSE per pause hint; legal range 1..255.
- BUS_TIMEOUT, 255: max MEM cycles before FAULT; legal range 2..255.
- clk  in  1  core clock; all state changes on its rising edge.
- rst  in  1  one clock; reset is asynchronous and active-low (rst=0 resets immediately; release is synchronised externally).
- rb_ready  in  1  register bank initialised.
- pc_end  in  1  program end reached.
- is_load  in  1  decoder: current instruction reads the data bus.
- is_store  in  1  decoder: current instruction writes the data bus.
- reg_w_dec  in  1  decoder: instruction writes rd.
- pause_req  in  1  Zihintpause decoder: pause hint.
- bus_ready  in  1  DataBusControl ready.
- bus_busy  in  1  DataBusControl busy.
- pc_enable  out  1  advance PC (one cycle per instruction).
- reg_we  out  1  register-bank write strobe.
- bus_rd  out  1  data-bus read request.
- bus_wr  out  1  data-bus write request.
- pause_active  out  1  core stalled by pause hint.
- halted  out  1  HALT state.
- fault  out  1  bus timeout occurred (sticky).
- state  out  3  current state encoding, for debug.
- retired  out  32  count of completed instructions.

## Operation
- States (encoding): RST_WAIT=0, FETCH=1, EXEC=2, MEM=3, WB=4, PAUSE=5, HALT=6, FAULT=7.
- All outputs are Moore: they are decoded from registered state and flags only.
- RST_WAIT: stay while rb_ready=0. Otherwise go to FETCH.
- FETCH: one cycle for synchronous program memory read. Go to EXEC.
- EXEC: latch the kind flags. Priority: pc_end → HALT; pause_req → PAUSE (pcnt ← PAUSE_CYCLES−1); is_load|is_store → MEM (wcnt ← 0); else → WB.
- EXEC latches wb_en = reg_w_dec & ~is_store & ~pause_req.
- If is_load and is_store are both set, treat the instruction as a load.
- MEM: bus_rd=ld_latched, bus_wr=st_latched, held for the whole state. wcnt increments each cycle, saturating at 255.
- MEM completes when wcnt≥1 and bus_ready=1 and bus_busy=0, then go to WB. If wcnt reaches BUS_TIMEOUT-1 without completing, go to FAULT.
- WB: pc_enable=1, reg_we=wb_en, retired += 1 (wraps 0xFFFFFFFF→0). Go to FETCH.
- PAUSE: pause_active=1. pcnt decrements each cycle; at pcnt=0 go to WB so the PC steps past the hint.
- HALT: halted=1. Sticky until reset.
- FAULT: fault=1. Sticky until reset. No strobes are asserted.
- rb_ready=0 in any state except HALT/FAULT: go to RST_WAIT next cycle. Strobes drop, and the in-flight instruction is abandoned with no pc_enable and no retire.
- Reset (rst=0): state=RST_WAIT; all strobes, pause_active, halted and fault are 0; retired=0; counters and latched flags are 0.

## Timing
- ALU/branch/jump instruction: FETCH, EXEC, WB = 3 cycles; pc_enable and reg_we high together for exactly 1 cycle.
- Load/store: FETCH, EXEC, MEM×n, WB, with n ≥ 2. Minimum 5 cycles.
- The bus strobe rises the cycle after EXEC and falls the cycle WB is entered.
- Pause: FETCH, EXEC, PAUSE×PAUSE_CYCLES, WB.
- No strobe is ever asserted outside MEM/WB. pc_enable and bus_rd/bus_wr are never high in the same cycle.
- rst assertion clears outputs without waiting for clk.

## Test plan
- Reset, rb_ready=1 at cycle 3, ALU op with reg_w_dec=1 → state goes 0→1→2→4; pc_enable=reg_we=1 only in cycle 6; retired=1.
- Load with bus_busy=1 for 4 MEM cycles, then ready → bus_rd high 5 cycles, then WB with reg_we=1; store of the same length → bus_wr 5 cycles, reg_we=0.
- BUS_TIMEOUT=8, bus_ready held 0 during a load → FAULT after 8 MEM cycles; fault=1, bus_rd=0, no further pc_enable for 20 cycles.
- pause_req with PAUSE_CYCLES=16 → pause_active high exactly 16 cycles, then one pc_enable, reg_we=0.
- pc_end=1 together with pause_req in EXEC → HALT (halted=1), no pc_enable; rst pulse returns state=0 and retired=0.
- rb_ready dropped mid-MEM → bus_rd falls next cycle, state=0, retired unchanged; after rb_ready returns, the same instruction re-fetches and retires once.
